save_level_ctrl: RTL and testbench
==================================

Name: save_level_ctrl

Overview:
Control FSM that writes the live 60-cell board register file back into level memory. It is the writer counterpart of the level-load path: it reads register locations in pairs and writes them to one of two 60-word level slots in RAM. It sits between the board register file (read ports) and the level RAM (write ports). It uses a start/ready/done handshake to talk to the top-level game controller.

Parameters:
DATA_W, 16, width of one board row word (register-file read data and RAM write data)
HALF, 30, cells handled per port; total cells = 2*HALF = 60
LEVEL_STRIDE, 60, RAM word offset between level 0 and level 1 slots

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request save; level-sensitive, held by requester until done observed
levelSel  input  1  0 = save to level slot 0, 1 = save to level slot 1; sampled only when start is accepted
regLoc0  output  6  register-file read address, port 0
regLoc1  output  6  register-file read address, port 1
regData0  input  DATA_W  read data port 0; valid one cycle after regLoc0 (registered read)
regData1  input  DATA_W  read data port 1; valid one cycle after regLoc1
memAddr0  output  7  RAM write address, port 0
memAddr1  output  7  RAM write address, port 1
memWrData0  output  DATA_W  RAM write data port 0
memWrData1  output  DATA_W  RAM write data port 1
memWe0  output  1  RAM write enable port 0
memWe1  output  1  RAM write enable port 1
ready  output  1  high in idle; a start will be accepted
done  output  1  high while in done state

Behaviour:
- Clock and reset: clk is the only clock. reset is synchronous, active-high, and takes priority over all other inputs.
- On reset:
  - state = s_idle, count = 0, latched level = 0.
  - ready = 1, done = 0, memWe0/1 = 0.
  - regLoc0 = 0, regLoc1 = 30, memAddr0 = 0, memAddr1 = 30.
- Internal state: 5-bit count (0..29) and a 1-bit latched level (lvl).
- States: s_idle, s_read, s_write, s_done.
  - s_idle: ready = 1. If start = 1, go to s_read, clear count to 0, and latch lvl <= levelSel. Otherwise stay.
  - s_read: regLoc0 = count, regLoc1 = count + 30. No write. Next state is always s_write.
  - s_write: regLoc held at the s_read values. memWe0 = memWe1 = 1. memWrData0 = regData0 and memWrData1 = regData1, both passed through combinationally. If count == 29, go to s_done; otherwise count <= count + 1 and go to s_read.
  - s_done: done = 1. Stay while start = 1. When start = 0, go to s_idle (one cycle later ready = 1).
- Address mapping (7-bit result, max 119, no overflow):
  - memAddr0 = count + (lvl ? 60 : 0).
  - memAddr1 = count + 30 + (lvl ? 60 : 0).
- memAddr and regLoc are driven in every state. Their values are only meaningful during s_read and s_write.
- Latency:
  - Start sampled at edge E0.
  - s_read occurs on cycles 1, 3, …, 59; s_write on cycles 2, 4, …, 60.
  - done is asserted from cycle 61.
  - Exactly 30 write pulses per port, 60 RAM words total per save.
- Writes happen only in s_write; memWe is never high in any other state.
- levelSel changes after acceptance are ignored until the next start.
- start deassertion mid-save is ignored; the save runs to completion.
- Reset mid-save: next state is s_idle and no further writes occur. The RAM may hold a partial save; that is acceptable.
- start high at the same edge as reset: reset wins and the block is in s_idle with ready = 1. If start is still high at the next edge, the save begins.
- start held high through s_done: the block stays in s_done. A new save requires start low, then high again.

Test Plan:
- Reset check: assert reset for 2 cycles -> ready=1, done=0, memWe0/1=0, regLoc0=0, regLoc1=30.
- Save to level slot 0:
  - Stimulus: register file model holds data[i] = 16'h0100 + i; pulse start with levelSel=0.
  - Required: RAM[i] = 16'h0100 + i for i = 0..59; RAM[60..119] untouched; 30 write pulses per port; done first high 61 cycles after the accepting edge.
- Save to level slot 1:
  - Stimulus: same data, levelSel=1; toggle levelSel every cycle during the save.
  - Required: RAM[60+i] = 16'h0100 + i; RAM[0..59] unchanged from the prior contents.
- Done handshake: hold start high for 100 cycles -> done stays 1 and no extra writes occur; drop start -> done=0 and ready=1 on the next cycle; raise start again -> a second save runs.
- Reset mid-save: assert reset on cycle 20 of the save -> state returns to idle and memWe stays 0 afterwards. RAM[0..9] and RAM[30..39] hold the new data; the remaining words are unchanged.
- Simultaneous start and reset: start=1 and reset=1 at the same edge -> no write; the next edge with reset=0 accepts start, and the first s_read follows.

Source files
------------

// File: rtl/save_level_ctrl_if.sv
// Save-path bundle: game-controller handshake,
// board register-file read ports and level RAM write ports.
interface save_level_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              levelSel;
  logic              ready;
  logic              done;
  logic [5:0]        regLoc0;
  logic [5:0]        regLoc1;
  logic [DATA_W-1:0] regData0;
  logic [DATA_W-1:0] regData1;
  logic [6:0]        memAddr0;
  logic [6:0]        memAddr1;
  logic [DATA_W-1:0] memWrData0;
  logic [DATA_W-1:0] memWrData1;
  logic              memWe0;
  logic              memWe1;

  modport slave (
    input  start,
    input  levelSel,
    input  regData0,
    input  regData1,
    output ready,
    output done,
    output regLoc0,
    output regLoc1,
    output memAddr0,
    output memAddr1,
    output memWrData0,
    output memWrData1,
    output memWe0,
    output memWe1
  );

  modport master (
    output start,
    output levelSel,
    output regData0,
    output regData1,
    input  ready,
    input  done,
    input  regLoc0,
    input  regLoc1,
    input  memAddr0,
    input  memAddr1,
    input  memWrData0,
    input  memWrData1,
    input  memWe0,
    input  memWe1
  );
endinterface

// File: rtl/save_level_ctrl.sv
// Copies the 60-cell board register file into one
// of two level slots in RAM, two cells per write cycle.
module save_level_ctrl #(
  parameter int DATA_W       = 16,
  parameter int HALF         = 30,
  parameter int LEVEL_STRIDE = 60
) (
  input  logic              clk,
  input  logic              reset,
  save_level_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    s_idle,
    s_read,
    s_write,
    s_done
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] count;
  logic [4:0] count_nxt;
  logic       lvl;
  logic       lvl_nxt;
  logic [6:0] base;

  logic [DATA_W-1:0] wd0;
  logic [DATA_W-1:0] wd1;

  // state, cell counter and latched level slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= s_idle;
      count <= '0;
      lvl   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      lvl   <= lvl_nxt;
    end
  end

  // next-state: read/write alternate until the last pair
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    lvl_nxt   = lvl;
    unique case (state)
      s_idle: begin
        if (bus.start) begin
          state_nxt = s_read;
          count_nxt = '0;
          lvl_nxt   = bus.levelSel;
        end
      end
      s_read: begin
        state_nxt = s_write;
      end
      s_write: begin
        if (count == 5'(HALF - 1)) begin
          state_nxt = s_done;
        end else begin
          count_nxt = count + 5'd1;
          state_nxt = s_read;
        end
      end
      s_done: begin
        if (!bus.start) state_nxt = s_idle;
      end
      default: state_nxt = s_idle;
    endcase
  end

  assign base = lvl ? 7'(LEVEL_STRIDE) : 7'd0;

  assign wd0 = bus.regData0;
  assign wd1 = bus.regData1;

  assign bus.regLoc0    = 6'(count);
  assign bus.regLoc1    = 6'(count) + 6'(HALF);
  assign bus.memAddr0   = 7'(count) + base;
  assign bus.memAddr1   = 7'(count) + 7'(HALF) + base;
  assign bus.memWrData0 = wd0;
  assign bus.memWrData1 = wd1;
  assign bus.memWe0     = (state == s_write);
  assign bus.memWe1     = (state == s_write);
  assign bus.ready      = (state == s_idle);
  assign bus.done       = (state == s_done);

endmodule

// File: tb/tb_save_level_ctrl.sv
// Scoreboard bench for save_level_ctrl: expected
// writes are queued per port and matched at negedge.
module tb_save_level_ctrl;

  typedef struct {
    logic [6:0]  a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_req = 1'b1;
  logic [15:0] rf_base = 16'h0;

  logic [15:0] ram [120];
  logic [15:0] exp_ram [120];

  wr_t q0[$];
  wr_t q1[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr0 = 0;
  int wr1 = 0;

  save_level_ctrl_if #(.DATA_W(16)) bus();

  save_level_ctrl #(
    .DATA_W(16),
    .HALF(30),
    .LEVEL_STRIDE(60)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // registered-read board register file model
  always @(posedge clk) begin
    bus.regData0 <= rf_base + 16'(bus.regLoc0);
    bus.regData1 <= rf_base + 16'(bus.regLoc1);
  end

  // level RAM model
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 120; i++) ram[i] <= 16'hA000 + 16'(i);
    end else begin
      if (bus.memWe0) ram[bus.memAddr0] <= bus.memWrData0;
      if (bus.memWe1) ram[bus.memAddr1] <= bus.memWrData1;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // monitor: every write pulse must match the queue head
  always @(negedge clk) begin
    wr_t e;
    if (bus.memWe0) begin
      wr0++;
      if (q0.size() == 0) begin
        total_cnt++;
        $display("FAIL we0_unexpected: addr %0d data %0h",
                 bus.memAddr0, bus.memWrData0);
      end else begin
        e = q0.pop_front();
        chk("wr0", {bus.memAddr0, bus.memWrData0}, {e.a, e.d});
      end
    end
    if (bus.memWe1) begin
      wr1++;
      if (q1.size() == 0) begin
        total_cnt++;
        $display("FAIL we1_unexpected: addr %0d data %0h",
                 bus.memAddr1, bus.memWrData1);
      end else begin
        e = q1.pop_front();
        chk("wr1", {bus.memAddr1, bus.memWrData1}, {e.a, e.d});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pairs(input logic lv,
                            input logic [15:0] base,
                            input int n);
    logic [6:0] off;
    off = lv ? 7'd60 : 7'd0;
    for (int k = 0; k < n; k++) begin
      q0.push_back('{off + 7'(k), base + 16'(k)});
      q1.push_back('{off + 7'(k + 30), base + 16'(k + 30)});
      exp_ram[off + 7'(k)]      = base + 16'(k);
      exp_ram[off + 7'(k + 30)] = base + 16'(k + 30);
    end
  endtask

  task automatic check_ram(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 120; i++)
      if (ram[i] !== exp_ram[i]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic run_save(input logic lv,
                          input logic [15:0] base,
                          input logic tog,
                          input logic hold);
    int cyc;
    rf_base = base;
    wr0 = 0;
    wr1 = 0;
    push_pairs(lv, base, 30);
    bus.levelSel = lv;
    bus.start = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    cyc = 1;
    chk("read_after_accept",
        {bus.ready, bus.memWe0, bus.regLoc0, bus.regLoc1},
        {1'b0, 1'b0, 6'd0, 6'd30});
    while (!bus.done && cyc < 200) begin
      if (tog) bus.levelSel = ~bus.levelSel;
      tick();
      cyc++;
    end
    chk("done_cycle", cyc, 61);
    chk("writes_p0", wr0, 30);
    chk("writes_p1", wr1, 30);
    if (!hold) begin
      tick();
      chk("ready_after_done", {bus.ready, bus.done}, 2'b10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    bus.start = 1'b0;
    bus.levelSel = 1'b0;
    for (int i = 0; i < 120; i++) exp_ram[i] = 16'hA000 + 16'(i);

    // reset state
    tick();
    tick();
    init_req = 1'b0;
    chk("rst_ready_done", {bus.ready, bus.done}, 2'b10);
    chk("rst_we", {bus.memWe0, bus.memWe1}, 2'b00);
    chk("rst_regloc", {bus.regLoc0, bus.regLoc1}, {6'd0, 6'd30});
    chk("rst_memaddr", {bus.memAddr0, bus.memAddr1}, {7'd0, 7'd30});
    reset = 1'b0;
    tick();

    // save to slot 0
    run_save(1'b0, 16'h0100, 1'b0, 1'b0);
    check_ram("ram_slot0");

    // save to slot 1 with levelSel toggling
    run_save(1'b1, 16'h0100, 1'b1, 1'b0);
    check_ram("ram_slot1");

    // start held through done
    run_save(1'b0, 16'h0300, 1'b0, 1'b1);
    ok = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!bus.done) ok = 0;
    end
    chk("done_held", ok, 1);
    chk("no_extra_writes", wr0 + wr1, 60);
    bus.start = 1'b0;
    tick();
    chk("drop_start", {bus.ready, bus.done}, 2'b10);
    run_save(1'b1, 16'h0400, 1'b0, 1'b0);
    check_ram("ram_hold_resave");

    // reset during write cycle 20 (pair 9)
    rf_base = 16'h0200;
    wr0 = 0;
    wr1 = 0;
    push_pairs(1'b0, 16'h0200, 10);
    bus.levelSel = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    chk("midrst_idle", {bus.ready, bus.done, bus.memWe0}, 3'b100);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("midrst_wr0", wr0, 10);
    chk("midrst_wr1", wr1, 10);
    chk("midrst_ready", bus.ready, 1'b1);
    check_ram("ram_midrst");

    // start and reset on the same edge
    wr0 = 0;
    wr1 = 0;
    bus.start = 1'b1;
    bus.levelSel = 1'b1;
    reset = 1'b1;
    tick();
    chk("sim_rst_idle", {bus.ready, bus.memWe0}, 2'b10);
    reset = 1'b0;
    run_save(1'b1, 16'h0500, 1'b0, 1'b0);
    check_ram("ram_sim_rst");

    repeat (3) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
